prp_list_writer: RTL and testbench
==================================

Name: prp_list_writer

Overview:
- Consumer-side counterpart of the PRP entry source.
- Drains 64-bit PRP entries through a pop/empty first-word-fall-through interface and writes them as a contiguous PRP list into DDR over an AXI4 write master.
- Sits between the PRP entry generator and the DDR interconnect, so the NVMe data path can hand PRP2 (list pointer) to the SSD.
- Issues INCR bursts, never crosses a 4 KB boundary, and reports done/error per list.

Parameters:
- DATA_WIDTH, 64, AXI wdata and PRP entry width; only 64 is supported.
- MAX_BURST_LEN, 16, maximum beats per AXI burst (1..256).
- ADDR_WIDTH, 64, AXI address width.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low.
- start  in  1  single-cycle pulse; accepted only in IDLE.
- list_base_addr  in  64  byte address of PRP list; bits [2:0] ignored (treated as 0).
- entry_count  in  9  number of PRP entries to write (0..511).
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at list completion.
- error  out  1  sticky; set on non-OKAY bresp; cleared on next accepted start.
- fifo_data  in  DATA_WIDTH  current head entry (valid when !fifo_empty).
- fifo_empty  in  1  source has no entry.
- fifo_pop  out  1  consume head entry.
- m_axi_awaddr  out  ADDR_WIDTH  burst start address.
- m_axi_awlen  out  8  beats-1.
- m_axi_awsize  out  3  constant 3'b011.
- m_axi_awburst  out  2  constant 2'b01 (INCR).
- m_axi_awvalid  out  1  ;  m_axi_awready  in  1.
- m_axi_wdata  out  DATA_WIDTH  =fifo_data.
- m_axi_wstrb  out  8  constant 8'hFF.
- m_axi_wlast  out  1  last beat of burst.
- m_axi_wvalid  out  1  ;  m_axi_wready  in  1.
- m_axi_bresp  in  2  ;  m_axi_bvalid  in  1  ;  m_axi_bready  out  1.

Behaviour:
- Reset values: busy=0, done=0, error=0, fifo_pop=0, awvalid=0, wvalid=0, wlast=0, bready=0, awaddr=0, awlen=0; FSM in IDLE.
- States: IDLE, CALC, AW, W, B, DONE.
- IDLE: on start, latch addr={list_base_addr[63:3],3'b0} and remaining=entry_count, clear error, set busy, go to CALC. Start in any other state is ignored.
- CALC (1 cycle): if remaining==0, go to DONE. Otherwise beats=min(remaining, MAX_BURST_LEN, (4096-addr[11:0])>>3); awlen=beats-1; go to AW.
- AW: awvalid=1 and awaddr/awlen held stable until awready; on handshake go to W. No W beats are issued before the AW handshake.
- W: wvalid=!fifo_empty; fifo_pop=wvalid&wready (same cycle, combinational); wdata=fifo_data.
  - wlast=1 when beat counter==awlen.
  - An empty source stalls with wvalid=0 and no timeout.
  - On the last beat handshake go to B.
- B: bready=1. On bvalid:
  - if bresp!=2'b00, set error and go to DONE (abort remaining entries; they stay in the source).
  - else addr+=beats*8, remaining-=beats; go to CALC.
- DONE: done=1 for exactly one cycle, busy=0 the next cycle, return to IDLE.
- Arithmetic: remaining and beat counters are 9 bits; the address adds at 64 bits with no wrap check.
- Max outstanding: one burst (single AW/B in flight).
- Synchronous reset mid-operation returns to IDLE immediately. No AXI completion is awaited; the interconnect is reset together with the block.

Decomposition:
- Shared package prp_pkg: AXI_SIZE_8B=3'b011, AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00, PAGE_BYTES=4096, PRP_ENTRY_BYTES=8, and an enumerated FSM state type.
- One natural sub-module, prp_burst_calc: combinational min(remaining, MAX_BURST_LEN, bytes-to-4KB/8) producing beats and awlen. Kept separate for unit-level checking.

Test Plan:
- Base 0x10_0000_0000, count=3, source always ready -> one AW (awaddr=0x10_0000_0000, awlen=2), 3 W beats with wlast on the 3rd, done pulse, error=0.
- Count=20 at 0x10_0000_0000 -> two bursts: awlen=15 @0x..0000, then awlen=3 @0x..0080; 20 pops total.
- Base 0x10_0000_0FF0, count=4 -> awlen=1 @0x..0FF0, then awlen=1 @0x..1000; no burst crosses 4 KB.
- fifo_empty asserted for 5 cycles mid-burst (count=8) -> wvalid=0 and fifo_pop=0 during the gap; data order preserved; done after the 8th beat.
- First burst bresp=2'b10 with count=20 -> error=1, done pulse, no second AW, exactly 16 pops.
- Count=0 -> no AXI activity, done 2 cycles after start; aresetn low during W of a 16-beat burst -> all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/prp_pkg.sv
// Shared definitions for the PRP list writer: AXI encodings, page/entry
// geometry and the writer FSM state type.
package prp_pkg;

  localparam logic [2:0] AXI_SIZE_8B     = 3'b011;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam int         PAGE_BYTES      = 4096;
  localparam int         PRP_ENTRY_BYTES = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_AW,
    ST_W,
    ST_B,
    ST_DONE
  } prp_state_e;

endpackage

// File: rtl/prp_list_writer_if.sv
// AXI4 write-channel bundle (AW, W, B) used by the PRP list writer.
// master : drives AW/W payload and valids, bready; samples readies and bresp.
// slave  : the interconnect side, mirror image of master.
interface prp_list_writer_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [7:0]            wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/prp_burst_calc.sv
// Burst sizing for the PRP list writer.
// Ports:
//   remaining_i  entries still to write (non-zero when the result is used)
//   page_off_i   entry index within the current 4 KB page (addr[11:3])
//   beats_o      min(remaining, MAX_BURST_LEN, entries left in the page)
//   awlen_o      beats_o - 1, AXI length encoding
module prp_burst_calc
  import prp_pkg::*;
#(
  parameter int MAX_BURST_LEN = 16
) (
  input  logic [8:0] remaining_i,
  input  logic [8:0] page_off_i,
  output logic [8:0] beats_o,
  output logic [7:0] awlen_o
);
  localparam logic [9:0] PAGE_BEATS = 10'(PAGE_BYTES / PRP_ENTRY_BYTES);
  localparam logic [9:0] MAX_BEATS  = 10'(MAX_BURST_LEN);

  logic [9:0] to_page;
  logic [9:0] limit;

  always_comb begin
    // Ranges 1..512, so 10 bits are needed before the min against MAX_BEATS.
    to_page = PAGE_BEATS - {1'b0, page_off_i};
    limit   = (MAX_BEATS < to_page) ? MAX_BEATS : to_page;
    beats_o = ({1'b0, remaining_i} < limit) ? remaining_i : limit[8:0];
    awlen_o = 8'(beats_o - 9'd1);
  end
endmodule

// File: rtl/prp_list_writer.sv
// PRP list writer: drains 64-bit PRP entries from a first-word-fall-through
// source and writes them as a contiguous list in memory using single
// outstanding AXI4 INCR bursts that never cross a 4 KB page.
// Ports:
//   aclk, aresetn           clock, synchronous active-low reset
//   start, list_base_addr,
//   entry_count             list request (accepted only when idle)
//   busy, done, error       status; error is sticky until the next start
//   fifo_data, fifo_empty,
//   fifo_pop                entry source; pop is combinational with the W beat
//   m_axi                   AXI4 write master (AW/W/B)
module prp_list_writer
  import prp_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int MAX_BURST_LEN = 16,
  parameter int ADDR_WIDTH    = 64
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic [63:0]           list_base_addr,
  input  logic [8:0]            entry_count,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  prp_list_writer_if.master     m_axi
);
  prp_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [8:0]            remaining_q, remaining_d;
  logic [8:0]            beats_q, beats_d;
  logic [7:0]            awlen_q, awlen_d;
  logic [8:0]            beat_cnt_q, beat_cnt_d;
  logic                  error_q, error_d;

  logic [8:0] calc_beats;
  logic [7:0] calc_awlen;
  logic       awvalid, wvalid, wlast, bready;

  prp_burst_calc #(.MAX_BURST_LEN(MAX_BURST_LEN)) u_calc (
    .remaining_i (remaining_q),
    .page_off_i  (addr_q[11:3]),
    .beats_o     (calc_beats),
    .awlen_o     (calc_awlen)
  );

  always_ff @(posedge aclk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      beats_q     <= '0;
      awlen_q     <= '0;
      beat_cnt_q  <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      beats_q     <= beats_d;
      awlen_q     <= awlen_d;
      beat_cnt_q  <= beat_cnt_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    beats_d     = beats_q;
    awlen_d     = awlen_q;
    beat_cnt_d  = beat_cnt_q;
    error_d     = error_q;
    done        = 1'b0;
    awvalid     = 1'b0;
    wvalid      = 1'b0;
    wlast       = 1'b0;
    bready      = 1'b0;
    fifo_pop    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d      = {list_base_addr[ADDR_WIDTH-1:3], 3'b000};
          remaining_d = entry_count;
          error_d     = 1'b0;
          state_d     = ST_CALC;
        end
      end
      ST_CALC: begin
        if (remaining_q == 9'd0) begin
          state_d = ST_DONE;
        end else begin
          beats_d = calc_beats;
          awlen_d = calc_awlen;
          state_d = ST_AW;
        end
      end
      ST_AW: begin
        awvalid = 1'b1;
        if (m_axi.awready) begin
          beat_cnt_d = '0;
          state_d    = ST_W;
        end
      end
      ST_W: begin
        wvalid = !fifo_empty;
        wlast  = (beat_cnt_q == {1'b0, awlen_q});
        if (wvalid && m_axi.wready) begin
          fifo_pop   = 1'b1;
          beat_cnt_d = beat_cnt_q + 9'd1;
          if (wlast) state_d = ST_B;
        end
      end
      ST_B: begin
        bready = 1'b1;
        if (m_axi.bvalid) begin
          if (m_axi.bresp != AXI_RESP_OKAY) begin
            // Abort: unwritten entries are left in the source.
            error_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            addr_d      = addr_q + {{(ADDR_WIDTH-12){1'b0}}, beats_q, 3'b000};
            remaining_d = remaining_q - beats_q;
            state_d     = ST_CALC;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy  = (state_q != ST_IDLE);
  assign error = error_q;

  assign m_axi.awaddr  = addr_q;
  assign m_axi.awlen   = awlen_q;
  assign m_axi.awsize  = AXI_SIZE_8B;
  assign m_axi.awburst = AXI_BURST_INCR;
  assign m_axi.awvalid = awvalid;
  assign m_axi.wdata   = fifo_data;
  assign m_axi.wstrb   = 8'hFF;
  assign m_axi.wlast   = wlast;
  assign m_axi.wvalid  = wvalid;
  assign m_axi.bready  = bready;
endmodule

// File: tb/tb_prp_list_writer.sv
// Directed bench for prp_list_writer: a queue-backed entry source, a simple
// AXI write slave with a toggling awready, and hand-computed expectations.
module tb_prp_list_writer;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start = 1'b0;
  logic [63:0] list_base_addr = '0;
  logic [8:0]  entry_count = '0;
  logic        busy, done, error;
  logic [63:0] fifo_data = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_pop;

  prp_list_writer_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) m_axi ();

  prp_list_writer #(.DATA_WIDTH(64), .MAX_BURST_LEN(16), .ADDR_WIDTH(64)) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .start          (start),
    .list_base_addr (list_base_addr),
    .entry_count    (entry_count),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .fifo_data      (fifo_data),
    .fifo_empty     (fifo_empty),
    .fifo_pop       (fifo_pop),
    .m_axi          (m_axi.master)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Source and observation logs.
  logic [63:0] src_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] wdata_q[$];
  logic [63:0] aw_addr_q[$];
  int          aw_len_q[$];
  int          burst_beats_q[$];
  int cyc = 0;
  int pop_cnt = 0, done_cnt = 0, b_idx = 0, beat_run = 0;
  int start_cyc = 0, done_cyc = 0;
  int w_before_aw = 0, cross4k = 0, gap_viol = 0, gap_seen = 0;
  int err_burst = -1, gap_after = 0, gap_left = 0;
  bit aw_open = 0, b_pending = 0, gap = 0;

  // Monitor: samples pre-edge values at the active edge.
  always @(posedge aclk) begin
    if (!aresetn) begin
      aw_open   = 0;
      b_pending = 0;
      beat_run  = 0;
    end else begin
      if (start) start_cyc = cyc;
      if (m_axi.wvalid && !aw_open) w_before_aw++;
      if (fifo_empty && (m_axi.wvalid || fifo_pop)) gap_viol++;
      if (gap) gap_seen++;
      if (m_axi.awvalid && m_axi.awready) begin
        aw_addr_q.push_back(m_axi.awaddr);
        aw_len_q.push_back(int'(m_axi.awlen));
        if (int'(m_axi.awaddr[11:0]) + (int'(m_axi.awlen) + 1) * 8 > 4096) cross4k++;
        aw_open = 1;
      end
      if (m_axi.wvalid && m_axi.wready) begin
        wdata_q.push_back(m_axi.wdata);
        beat_run++;
        if (m_axi.wlast) begin
          burst_beats_q.push_back(beat_run);
          beat_run  = 0;
          aw_open   = 0;
          b_pending = 1;
        end
      end
      if (fifo_pop) begin
        pop_cnt++;
        if (src_q.size() > 0) void'(src_q.pop_front());
      end
      if (m_axi.bvalid && m_axi.bready) begin
        b_pending = 0;
        b_idx++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    cyc++;
  end

  // Source and AXI slave drive on the opposite edge.
  always @(negedge aclk) begin
    if (gap_left > 0 && pop_cnt >= gap_after) begin
      gap = 1;
      gap_left--;
    end else begin
      gap = 0;
    end
    fifo_empty     = (src_q.size() == 0) || gap;
    fifo_data      = (src_q.size() > 0) ? src_q[0] : 64'h0;
    m_axi.awready  = (cyc % 2) == 1;
    m_axi.wready   = 1'b1;
    m_axi.bvalid   = aresetn && b_pending;
    m_axi.bresp    = (b_idx == err_burst) ? 2'b10 : 2'b00;
  end

  task automatic clear_logs();
    src_q.delete(); exp_q.delete(); wdata_q.delete();
    aw_addr_q.delete(); aw_len_q.delete(); burst_beats_q.delete();
    pop_cnt = 0; done_cnt = 0; b_idx = 0;
    err_burst = -1; gap_after = 0; gap_left = 0;
  endtask

  task automatic fill(input int count, input int tag);
    for (int i = 0; i < count; i++) begin
      src_q.push_back(64'hC0DE_0000_0000_0000 | (64'(tag) << 32) | 64'(i));
      exp_q.push_back(64'hC0DE_0000_0000_0000 | (64'(tag) << 32) | 64'(i));
    end
  endtask

  task automatic kick(input logic [63:0] base, input int count);
    @(negedge aclk);
    start          = 1'b1;
    list_base_addr = base;
    entry_count    = 9'(count);
    @(negedge aclk);
    start          = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge aclk);
      if (done_cnt > 0) begin
        seen = 1;
        break;
      end
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    @(negedge aclk);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  task automatic check_data(input string tag);
    check({tag, "_nbeats"}, 64'(wdata_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wdata_q.size(); i++)
      check($sformatf("%s_wdata%0d", tag, i), wdata_q[i], exp_q[i]);
  endtask

  task automatic check_aw(input string tag, input int idx, input logic [63:0] addr, input int len);
    if (aw_addr_q.size() > idx) begin
      check($sformatf("%s_awaddr%0d", tag, idx), aw_addr_q[idx], addr);
      check($sformatf("%s_awlen%0d", tag, idx), 64'(aw_len_q[idx]), 64'(len));
    end else begin
      check($sformatf("%s_aw%0d_present", tag, idx), 64'(aw_addr_q.size()), 64'(idx + 1));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},    64'(busy), 64'd0);
    check({tag, "_done"},    64'(done), 64'd0);
    check({tag, "_error"},   64'(error), 64'd0);
    check({tag, "_pop"},     64'(fifo_pop), 64'd0);
    check({tag, "_awvalid"}, 64'(m_axi.awvalid), 64'd0);
    check({tag, "_wvalid"},  64'(m_axi.wvalid), 64'd0);
    check({tag, "_wlast"},   64'(m_axi.wlast), 64'd0);
    check({tag, "_bready"},  64'(m_axi.bready), 64'd0);
    check({tag, "_awaddr"},  m_axi.awaddr, 64'd0);
    check({tag, "_awlen"},   64'(m_axi.awlen), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge aclk);
    check_reset_outputs("rst");
    aresetn = 1'b1;
    @(negedge aclk);

    // T1: short list in one burst.
    clear_logs(); fill(3, 1);
    kick(64'h10_0000_0000, 3);
    check("t1_busy", 64'(busy), 64'd1);
    wait_done("t1");
    check_aw("t1", 0, 64'h10_0000_0000, 2);
    check("t1_naw", 64'(aw_addr_q.size()), 64'd1);
    check("t1_wlast_beat", 64'(burst_beats_q.size() > 0 ? burst_beats_q[0] : 0), 64'd3);
    check("t1_awsize", 64'(m_axi.awsize), 64'd3);
    check("t1_awburst", 64'(m_axi.awburst), 64'd1);
    check("t1_wstrb", 64'(m_axi.wstrb), 64'hFF);
    check("t1_error", 64'(error), 64'd0);
    check("t1_done_cnt", 64'(done_cnt), 64'd1);
    check_data("t1");

    // T2: 20 entries split at MAX_BURST_LEN.
    clear_logs(); fill(20, 2);
    kick(64'h10_0000_0000, 20);
    wait_done("t2");
    check("t2_naw", 64'(aw_addr_q.size()), 64'd2);
    check_aw("t2", 0, 64'h10_0000_0000, 15);
    check_aw("t2", 1, 64'h10_0000_0080, 3);
    check("t2_pops", 64'(pop_cnt), 64'd20);
    check_data("t2");

    // T3: list straddling a 4 KB page.
    clear_logs(); fill(4, 3);
    kick(64'h10_0000_0FF0, 4);
    wait_done("t3");
    check("t3_naw", 64'(aw_addr_q.size()), 64'd2);
    check_aw("t3", 0, 64'h10_0000_0FF0, 1);
    check_aw("t3", 1, 64'h10_0000_1000, 1);
    check_data("t3");

    // T4: source underrun mid-burst; low address bits ignored.
    clear_logs(); fill(8, 4);
    gap_after = 3; gap_left = 5; gap_seen = 0; gap_viol = 0;
    kick(64'h10_0000_2007, 8);
    wait_done("t4");
    check_aw("t4", 0, 64'h10_0000_2000, 7);
    check("t4_gap_cycles", 64'(gap_seen), 64'd5);
    check("t4_gap_viol", 64'(gap_viol), 64'd0);
    check("t4_pops", 64'(pop_cnt), 64'd8);
    check_data("t4");

    // T5: SLVERR on the first burst aborts the list.
    clear_logs(); fill(20, 5);
    err_burst = 0;
    kick(64'h10_0000_0000, 20);
    wait_done("t5");
    check("t5_error", 64'(error), 64'd1);
    check("t5_naw", 64'(aw_addr_q.size()), 64'd1);
    check("t5_pops", 64'(pop_cnt), 64'd16);
    check("t5_left", 64'(src_q.size()), 64'd4);
    check("t5_done_cnt", 64'(done_cnt), 64'd1);

    // T6: empty list, also clears the sticky error.
    clear_logs();
    kick(64'h10_0000_3000, 0);
    check("t6_error_cleared", 64'(error), 64'd0);
    wait_done("t6");
    check("t6_naw", 64'(aw_addr_q.size()), 64'd0);
    check("t6_pops", 64'(pop_cnt), 64'd0);
    check("t6_latency", 64'(done_cyc - start_cyc), 64'd2);

    // T7: reset in the middle of a 16-beat burst.
    clear_logs(); fill(16, 7);
    kick(64'h10_0000_4000, 16);
    for (int i = 0; i < 200 && pop_cnt < 5; i++) @(negedge aclk);
    check("t7_reached_w", 64'(pop_cnt >= 5), 64'd1);
    aresetn = 1'b0;
    @(negedge aclk);
    check_reset_outputs("t7_rst");
    aresetn = 1'b1;
    clear_logs();
    @(negedge aclk);

    check("proto_w_before_aw", 64'(w_before_aw), 64'd0);
    check("proto_cross4k", 64'(cross4k), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
